// File: rtl/key_chunk_dispatcher_if.sv
// Core-side bus of the key chunk dispatcher: chunk requests and win reports
// from the arcfour cores, plus grants and chunk bounds returned to them.
//   master : dispatcher side (drives core_grant, chunk_base, chunk_last)
//   slave  : core-array side (drives core_req, core_found, core_key)
interface key_chunk_dispatcher_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned KEY_WIDTH = 24
);
   logic [NUM_CORES-1:0]           core_req;
   logic [NUM_CORES-1:0]           core_found;
   logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
   logic [NUM_CORES-1:0]           core_grant;
   logic [KEY_WIDTH-1:0]           chunk_base;
   logic [KEY_WIDTH-1:0]           chunk_last;

   modport master (
      input  core_req, core_found, core_key,
      output core_grant, chunk_base, chunk_last
   );

   modport slave (
      output core_req, core_found, core_key,
      input  core_grant, chunk_base, chunk_last
   );
endinterface

// File: rtl/key_chunk_dispatcher.sv
// Dynamic key-space scheduler for the parallel RC4 cracking array.
// Hands fixed-size key chunks to idle cores round-robin, detects the first
// winning core or key-space exhaustion, and broadcasts halt.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start, abort          1-cycle control pulses (abort wins over start)
//   bus (master)          core_req/core_found/core_key in, core_grant/chunk_base/chunk_last out
//   halt, busy            halt high in IDLE/SUCCESS/EXHAUSTED; busy in DISPATCH/DRAIN
//   success, exhausted    search outcome levels
//   found_key, found_core key and index of the winning core
// Optional build macro KEY_DISPATCH_PERF_EN adds chunks_issued, a saturating
// grant counter cleared on start/abort/reset.
module key_chunk_dispatcher #(
   parameter int unsigned         NUM_CORES     = 4,
   parameter int unsigned         LOG_NUM_CORES = 2,
   parameter int unsigned         KEY_WIDTH     = 24,
   parameter int unsigned         CHUNK_LOG     = 10,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX      = 24'hffffff
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   key_chunk_dispatcher_if.master   bus,
   output logic                     halt,
   output logic                     busy,
   output logic                     success,
   output logic                     exhausted,
   output logic [KEY_WIDTH-1:0]     found_key,
   output logic [LOG_NUM_CORES-1:0] found_core
`ifdef KEY_DISPATCH_PERF_EN
   ,
   output logic [KEY_WIDTH-CHUNK_LOG:0] chunks_issued
`endif
);

   localparam int unsigned NB_W  = KEY_WIDTH + 1;
   localparam int unsigned CHUNK = 32'(1) << CHUNK_LOG;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_DRAIN,
      ST_SUCCESS,
      ST_EXHAUSTED
   } state_t;

   state_t                   state;
   logic [NB_W-1:0]          next_base;
   logic [LOG_NUM_CORES-1:0] rr_ptr;
   logic [NUM_CORES-1:0]     active;

   logic                     pick_vld_c;
   logic [LOG_NUM_CORES-1:0] pick_idx_c;
   int unsigned              cand_c;
   logic                     found_vld_c;
   logic [LOG_NUM_CORES-1:0] found_idx_c;
   logic [KEY_WIDTH-1:0]     found_key_c;
   logic [NB_W-1:0]          last_full_c;
   logic [KEY_WIDTH-1:0]     chunk_last_c;
   logic                     grant_take_c;

   // Status levels per state, ordered {halt, busy, success, exhausted}.
   function automatic logic [3:0] flags_of(input state_t s);
      case (s)
         ST_DISPATCH, ST_DRAIN: flags_of = 4'b0100;
         ST_SUCCESS:            flags_of = 4'b1010;
         ST_EXHAUSTED:          flags_of = 4'b1001;
         default:               flags_of = 4'b1000;
      endcase
   endfunction

   // Round-robin pick starting at rr_ptr, lowest-index winner, chunk bounds.
   always_comb begin
      pick_vld_c  = 1'b0;
      pick_idx_c  = '0;
      cand_c      = '0;
      found_vld_c = 1'b0;
      found_idx_c = '0;
      found_key_c = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         cand_c = (32'(rr_ptr) + k) % NUM_CORES;
         if (!pick_vld_c && bus.core_req[cand_c]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = LOG_NUM_CORES'(cand_c);
         end
      end
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
         if (!found_vld_c && bus.core_found[j]) begin
            found_vld_c = 1'b1;
            found_idx_c = LOG_NUM_CORES'(j);
            found_key_c = bus.core_key[j*KEY_WIDTH +: KEY_WIDTH];
         end
      end
      // next_base carries one extra bit so the sum cannot wrap below KEY_MAX.
      last_full_c  = next_base + NB_W'(CHUNK - 1);
      chunk_last_c = (last_full_c > NB_W'(KEY_MAX)) ? KEY_MAX : KEY_WIDTH'(last_full_c);
      // A win or abort suppresses any grant in the same cycle.
      grant_take_c = (state == ST_DISPATCH) && !abort && !found_vld_c && pick_vld_c;
   end

   // Search FSM with registered grant, chunk bounds, status and results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                                <= ST_IDLE;
         {halt, busy, success, exhausted}     <= flags_of(ST_IDLE);
         next_base                            <= '0;
         rr_ptr                               <= '0;
         active                               <= '0;
         bus.core_grant                       <= '0;
         bus.chunk_base                       <= '0;
         bus.chunk_last                       <= '0;
         found_key                            <= '0;
         found_core                           <= '0;
      end else begin
         bus.core_grant <= '0;
         case (state)
            ST_DISPATCH, ST_DRAIN: begin
               if (abort) begin
                  state                            <= ST_IDLE;
                  {halt, busy, success, exhausted} <= flags_of(ST_IDLE);
                  found_key                        <= '0;
                  found_core                       <= '0;
               end else if (found_vld_c) begin
                  state                            <= ST_SUCCESS;
                  {halt, busy, success, exhausted} <= flags_of(ST_SUCCESS);
                  found_key                        <= found_key_c;
                  found_core                       <= found_idx_c;
               end else begin
                  // A core asking for work has finished its previous chunk.
                  active <= active & ~bus.core_req;
                  if (grant_take_c) begin
                     active[pick_idx_c]         <= 1'b1;
                     bus.core_grant[pick_idx_c] <= 1'b1;
                     bus.chunk_base             <= KEY_WIDTH'(next_base);
                     bus.chunk_last             <= chunk_last_c;
                     next_base                  <= next_base + NB_W'(CHUNK);
                     rr_ptr <= LOG_NUM_CORES'((32'(pick_idx_c) + 1) % NUM_CORES);
                     if (chunk_last_c == KEY_MAX) begin
                        state <= ST_DRAIN;
                     end
                  end else if ((state == ST_DRAIN) && (active == '0)) begin
                     state                            <= ST_EXHAUSTED;
                     {halt, busy, success, exhausted} <= flags_of(ST_EXHAUSTED);
                  end
               end
            end
            default: begin
               if (abort) begin
                  state                            <= ST_IDLE;
                  {halt, busy, success, exhausted} <= flags_of(ST_IDLE);
                  found_key                        <= '0;
                  found_core                       <= '0;
               end else if (start) begin
                  state                            <= ST_DISPATCH;
                  {halt, busy, success, exhausted} <= flags_of(ST_DISPATCH);
                  next_base                        <= '0;
                  active                           <= '0;
                  found_key                        <= '0;
                  found_core                       <= '0;
               end
            end
         endcase
      end
   end

`ifdef KEY_DISPATCH_PERF_EN
   logic perf_clr_c;

   // Start is only honoured outside DISPATCH/DRAIN, so only then clears.
   assign perf_clr_c = abort || (start && (state != ST_DISPATCH) && (state != ST_DRAIN));

   // Saturating count of grants in the current search.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chunks_issued <= '0;
      end else if (perf_clr_c) begin
         chunks_issued <= '0;
      end else if (grant_take_c && (chunks_issued != '1)) begin
         chunks_issued <= chunks_issued + (KEY_WIDTH-CHUNK_LOG+1)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_key_chunk_dispatcher.sv
// Self-checking bench for key_chunk_dispatcher: directed vector table,
// hand-written corner sequences, and a randomized run against a reference model.
module tb_key_chunk_dispatcher;

   localparam int KMAX_A = 'h3F;
   localparam int KMAX_B = 'h25;

   logic clk;
   logic reset;
   logic start_a, abort_a, start_b, abort_b;
   logic halt_a, busy_a, success_a, exhausted_a;
   logic halt_b, busy_b, success_b, exhausted_b;
   logic [23:0] found_key_a, found_key_b;
   logic [1:0]  found_core_a, found_core_b;
   logic [3:0]  fl_a, fl_b;

   int n_vec = 0;
   int n_err = 0;

   key_chunk_dispatcher_if #(.NUM_CORES(4), .KEY_WIDTH(24)) bus_a ();
   key_chunk_dispatcher_if #(.NUM_CORES(4), .KEY_WIDTH(24)) bus_b ();

`ifdef KEY_DISPATCH_PERF_EN
   logic [14:0] ci_a, ci_b;
`endif

   key_chunk_dispatcher #(
      .NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24), .CHUNK_LOG(4), .KEY_MAX(24'h00003F)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .bus(bus_a),
      .halt(halt_a), .busy(busy_a), .success(success_a), .exhausted(exhausted_a),
      .found_key(found_key_a), .found_core(found_core_a)
`ifdef KEY_DISPATCH_PERF_EN
      , .chunks_issued(ci_a)
`endif
   );

   key_chunk_dispatcher #(
      .NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24), .CHUNK_LOG(4), .KEY_MAX(24'h000025)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .bus(bus_b),
      .halt(halt_b), .busy(busy_b), .success(success_b), .exhausted(exhausted_b),
      .found_key(found_key_b), .found_core(found_core_b)
`ifdef KEY_DISPATCH_PERF_EN
      , .chunks_issued(ci_b)
`endif
   );

   assign fl_a = {halt_a, busy_a, success_a, exhausted_a};
   assign fl_b = {halt_b, busy_b, success_b, exhausted_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       st;
      logic       ab;
      logic [3:0] req;
      logic [3:0] fnd;
      logic [3:0] gnt;
      logic [7:0] base;
      logic [7:0] last;
      logic [3:0] flg;   // {halt, busy, success, exhausted}
      logic [1:0] fc;
      logic [7:0] fk;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] req,
                               input logic [3:0] fnd, input logic [3:0] gnt,
                               input logic [7:0] base, input logic [7:0] last,
                               input logic [3:0] flg, input logic [1:0] fc, input logic [7:0] fk);
      vec_t v;
      v.st = st; v.ab = ab; v.req = req; v.fnd = fnd; v.gnt = gnt;
      v.base = base; v.last = last; v.flg = flg; v.fc = fc; v.fk = fk;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_WON, M_DONE} mphase_t;
   mphase_t     m_ph;
   int          m_next, m_rr;
   bit [3:0]    m_busy_core;
   logic [3:0]  e_grant;
   int          e_base, e_last, e_fc, e_fk;
   int unsigned keys[4];

   function automatic logic [3:0] m_flags(input mphase_t p);
      case (p)
         M_RUN, M_DRAIN: return 4'b0100;
         M_WON:          return 4'b1010;
         M_DONE:         return 4'b1001;
         default:        return 4'b1000;
      endcase
   endfunction

   task automatic model_reset();
      m_ph = M_IDLE; m_next = 0; m_rr = 0; m_busy_core = '0;
      e_grant = '0; e_base = 0; e_last = 0; e_fc = 0; e_fk = 0;
   endtask

   // One clock edge of the search, applied to the inputs sampled at that edge.
   task automatic model_edge(input bit st, input bit ab, input bit [3:0] req, input bit [3:0] fnd);
      int  g;
      int  c;
      bit  none_busy;
      g = -1;
      e_grant = '0;
      if (m_ph == M_RUN || m_ph == M_DRAIN) begin
         if (ab) begin
            m_ph = M_IDLE; e_fc = 0; e_fk = 0;
         end else if (fnd != 0) begin
            for (int j = 3; j >= 0; j--) if (fnd[j]) e_fc = j;
            e_fk = int'(keys[e_fc]);
            m_ph = M_WON;
         end else begin
            none_busy = (m_busy_core == 0);
            if (m_ph == M_RUN) begin
               for (int k = 0; k < 4; k++) begin
                  c = (m_rr + k) % 4;
                  if (g < 0 && req[c]) g = c;
               end
            end
            for (int i = 0; i < 4; i++) if (req[i]) m_busy_core[i] = 1'b0;
            if (g >= 0) begin
               m_busy_core[g] = 1'b1;
               e_grant[g] = 1'b1;
               e_base = m_next;
               e_last = (m_next + 15 > KMAX_A) ? KMAX_A : m_next + 15;
               m_next += 16;
               m_rr = (g + 1) % 4;
               if (e_last == KMAX_A) m_ph = M_DRAIN;
            end else if (m_ph == M_DRAIN && none_busy) begin
               m_ph = M_DONE;
            end
         end
      end else begin
         if (ab) begin
            m_ph = M_IDLE; e_fc = 0; e_fk = 0;
         end else if (st) begin
            m_ph = M_RUN; m_next = 0; m_busy_core = '0; e_fc = 0; e_fk = 0;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit          rs, ra;
      bit [3:0]    rq, rf;

      reset = 1'b1;
      start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
      bus_a.core_req = '0; bus_a.core_found = '0;
      bus_b.core_req = '0; bus_b.core_found = '0;
      bus_a.core_key = {24'h000044, 24'h000033, 24'h00002A, 24'h000011};
      bus_b.core_key = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset state
      chk("reset flags", 32'(fl_a), 32'(4'b1000));
      chk("reset grant", 32'(bus_a.core_grant), 32'h0);
      chk("reset found_key", 32'(found_key_a), 32'h0);
      chk("reset found_core", 32'(found_core_a), 32'h0);

      //            st ab req   fnd   gnt   base   last   flg      fc fk
      vecs[0]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b0100, 0, 8'h00);
      vecs[1]  = mk(0, 0, 4'hF, 4'h0, 4'h1, 8'h00, 8'h0F, 4'b0100, 0, 8'h00);
      vecs[2]  = mk(0, 0, 4'hF, 4'h0, 4'h2, 8'h10, 8'h1F, 4'b0100, 0, 8'h00);
      vecs[3]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'h20, 8'h2F, 4'b0100, 0, 8'h00);
      vecs[4]  = mk(0, 0, 4'hF, 4'h0, 4'h8, 8'h30, 8'h3F, 4'b0100, 0, 8'h00);
      vecs[5]  = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00, 4'b0100, 0, 8'h00);
      vecs[6]  = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1001, 0, 8'h00);
      vecs[7]  = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1001, 0, 8'h00);
      vecs[8]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b0100, 0, 8'h00);
      vecs[9]  = mk(0, 0, 4'hF, 4'h0, 4'h1, 8'h00, 8'h0F, 4'b0100, 0, 8'h00);
      vecs[10] = mk(0, 0, 4'h0, 4'h6, 4'h0, 8'h00, 8'h00, 4'b1010, 1, 8'h2A);
      vecs[11] = mk(0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1010, 1, 8'h2A);
      vecs[12] = mk(1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b0100, 0, 8'h00);
      vecs[13] = mk(0, 0, 4'h8, 4'h1, 4'h0, 8'h00, 8'h00, 4'b1010, 0, 8'h11);
      vecs[14] = mk(1, 1, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1000, 0, 8'h00);
      vecs[15] = mk(1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 4'b0100, 0, 8'h00);
      vecs[16] = mk(1, 0, 4'hF, 4'h0, 4'h2, 8'h00, 8'h0F, 4'b0100, 0, 8'h00);
      vecs[17] = mk(1, 0, 4'hF, 4'h0, 4'h4, 8'h10, 8'h1F, 4'b0100, 0, 8'h00);
      vecs[18] = mk(0, 1, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1000, 0, 8'h00);
      vecs[19] = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00, 4'b1000, 0, 8'h00);

      for (int r = 0; r < NV; r++) begin
         start_a = vecs[r].st; abort_a = vecs[r].ab;
         bus_a.core_req = vecs[r].req; bus_a.core_found = vecs[r].fnd;
         tick();
         chk($sformatf("row%0d grant", r), 32'(bus_a.core_grant), 32'(vecs[r].gnt));
         if (vecs[r].gnt != 0) begin
            chk($sformatf("row%0d chunk_base", r), 32'(bus_a.chunk_base), 32'(vecs[r].base));
            chk($sformatf("row%0d chunk_last", r), 32'(bus_a.chunk_last), 32'(vecs[r].last));
         end
         chk($sformatf("row%0d flags", r), 32'(fl_a), 32'(vecs[r].flg));
         chk($sformatf("row%0d found_core", r), 32'(found_core_a), 32'(vecs[r].fc));
         chk($sformatf("row%0d found_key", r), 32'(found_key_a), 32'(vecs[r].fk));
      end
      start_a = 0; abort_a = 0; bus_a.core_req = '0; bus_a.core_found = '0;

      // partial last chunk on the short key space
      start_b = 1; tick(); start_b = 0;
      bus_b.core_req = 4'hF;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk($sformatf("partial grant%0d", g), 32'(bus_b.core_grant), 32'(4'b0001 << g));
         chk($sformatf("partial base%0d", g), 32'(bus_b.chunk_base), 32'(g * 16));
         chk($sformatf("partial last%0d", g), 32'(bus_b.chunk_last), (g == 2) ? 32'h25 : 32'(g * 16 + 15));
      end
      tick();
      chk("partial drain grant", 32'(bus_b.core_grant), 32'h0);
      chk("partial drain flags", 32'(fl_b), 32'(4'b0100));
      tick();
      chk("partial exhausted flags", 32'(fl_b), 32'(4'b1001));
      bus_b.core_req = '0;

      // abort after two grants, restart from key 0 (rr pointer sits at core 3)
      start_a = 1; tick(); start_a = 0;
      bus_a.core_req = 4'hF;
      tick();
      chk("abort seq grant1", 32'(bus_a.core_grant), 32'h8);
      tick();
      chk("abort seq grant2 base", 32'(bus_a.chunk_base), 32'h10);
      abort_a = 1; tick(); abort_a = 0;
      chk("abort grant", 32'(bus_a.core_grant), 32'h0);
      chk("abort flags", 32'(fl_a), 32'(4'b1000));
      bus_a.core_req = '0;
      start_a = 1; tick(); start_a = 0;
      bus_a.core_req = 4'hF;
      tick();
      chk("restart grant", 32'(bus_a.core_grant), 32'h2);
      chk("restart base", 32'(bus_a.chunk_base), 32'h00);

      // asynchronous reset while a grant is showing
      tick();
      chk("pre-reset grant", 32'(bus_a.core_grant), 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("async reset grant", 32'(bus_a.core_grant), 32'h0);
      chk("async reset halt", 32'(halt_a), 32'h1);
      bus_a.core_req = '0;
      tick();
      reset = 1'b0;

      // randomized run against the reference model
      model_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         rs = ($urandom_range(0, 7) == 0);
         ra = ($urandom_range(0, 59) == 0);
         rq = 4'($urandom);
         rf = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         for (int k = 0; k < 4; k++) keys[k] = $urandom & 32'h00FF_FFFF;
         start_a = rs; abort_a = ra;
         bus_a.core_req = rq; bus_a.core_found = rf;
         bus_a.core_key = {24'(keys[3]), 24'(keys[2]), 24'(keys[1]), 24'(keys[0])};
         model_edge(rs, ra, rq, rf);
         tick();
         chk($sformatf("rand%0d grant", cyc), 32'(bus_a.core_grant), 32'(e_grant));
         if (e_grant != 0) begin
            chk($sformatf("rand%0d chunk_base", cyc), 32'(bus_a.chunk_base), 32'(e_base));
            chk($sformatf("rand%0d chunk_last", cyc), 32'(bus_a.chunk_last), 32'(e_last));
         end
         chk($sformatf("rand%0d flags", cyc), 32'(fl_a), 32'(m_flags(m_ph)));
         chk($sformatf("rand%0d found_core", cyc), 32'(found_core_a), 32'(e_fc));
         chk($sformatf("rand%0d found_key", cyc), 32'(found_key_a), 32'(e_fk));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
